// File: rtl/rob_pkg.sv
// Shared types and sizing for the rename stage: architectural/renamed uop
// records and the physical/architectural register index widths.
package rob_pkg;

    localparam int INSTR_Q_WIDTH = 4;
    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_PHYS_REGS = 128;
    localparam int PW            = $clog2(NUM_PHYS_REGS);
    localparam int AW            = $clog2(NUM_ARCH_REGS);
    localparam int FREE_W        = 2 * INSTR_Q_WIDTH + 2;
    localparam int PAYLOAD_W     = 16;

    typedef struct packed {
        logic                 lane_valid;
        logic                 has_dst;
        logic [AW-1:0]        arch_dst;
        logic [AW-1:0]        arch_src1;
        logic [AW-1:0]        arch_src2;
        logic [PAYLOAD_W-1:0] payload;
    } arch_uop_t;

    typedef struct packed {
        logic                 lane_valid;
        logic                 has_dst;
        logic [PW-1:0]        phys_dst;
        logic [PW-1:0]        old_phys_dst;
        logic [PW-1:0]        phys_src1;
        logic [PW-1:0]        phys_src2;
        logic [PAYLOAD_W-1:0] payload;
    } renamed_uop_t;

endpackage

// File: rtl/rat_bank.sv
// Register alias table: NUM_ARCH_REGS x PW map with read ports, lane-ordered
// write ports (highest port wins) and a whole-table copy-in used on flush.
module rat_bank #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int NUM_PHYS_REGS = 128,
    parameter int NRD           = 4,
    parameter int NWR           = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NRD-1:0][$clog2(NUM_ARCH_REGS)-1:0]         rd_addr,
    output logic [NRD-1:0][$clog2(NUM_PHYS_REGS)-1:0]         rd_data,
    input  logic [NWR-1:0]                                    wr_en,
    input  logic [NWR-1:0][$clog2(NUM_ARCH_REGS)-1:0]         wr_addr,
    input  logic [NWR-1:0][$clog2(NUM_PHYS_REGS)-1:0]         wr_data,
    input  logic                                              copy_en,
    input  logic [NUM_ARCH_REGS-1:0][$clog2(NUM_PHYS_REGS)-1:0] copy_data,
    output logic [NUM_ARCH_REGS-1:0][$clog2(NUM_PHYS_REGS)-1:0] map_next
);

    localparam int PW = $clog2(NUM_PHYS_REGS);

    logic [NUM_ARCH_REGS-1:0][PW-1:0] map_r;

    // Next map: copy-in overrides; otherwise later write ports override earlier ones.
    always_comb begin
        map_next = map_r;
        if (copy_en) begin
            map_next = copy_data;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                map_next[wr_addr[k]] = wr_en[k] ? wr_data[k] : map_next[wr_addr[k]];
            end
        end
    end

    // Read ports see the table as of the start of the cycle.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NRD; r++) begin
            rd_data[r] = map_r[rd_addr[r]];
        end
    end

    // Map storage; reset to the identity mapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                map_r[i] <= PW'(i);
            end
        end else begin
            map_r <= map_next;
        end
    end

endmodule

// File: rtl/rename_stage.sv
// Register rename stage: FRL allocation, speculative/retirement RATs with
// same-group bypass, one-deep output register. Option: RENAME_ZERO_REG_EN.
module rename_stage
    import rob_pkg::*;
#(
    parameter int WIDTH         = rob_pkg::INSTR_Q_WIDTH,
    parameter int NUM_ARCH_REGS = rob_pkg::NUM_ARCH_REGS,
    parameter int NUM_PHYS_REGS = rob_pkg::NUM_PHYS_REGS,
    parameter int FREE_W        = rob_pkg::FREE_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  arch_uop_t    [WIDTH-1:0]      in_uops,
    input  logic                          frl_valid_in,
    input  logic [FREE_W-1:0][PW-1:0]     frl_regs_in,
    output logic [FREE_W-1:0]             frl_acquire_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output renamed_uop_t [WIDTH-1:0]      out_uops,
    input  logic [WIDTH-1:0]              commit_valid,
    input  logic [WIDTH-1:0][AW-1:0]      commit_arch_dst,
    input  logic [WIDTH-1:0][PW-1:0]      commit_phys_dst,
    input  logic                          flush_in
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(FREE_W);

    logic [WIDTH-1:0]                 dst_s;
    logic [CW-1:0]                    n_dst_s;
    logic [WIDTH-1:0][IW-1:0]         frl_idx_s;
    logic                             accept_s;
    renamed_uop_t [WIDTH-1:0]         ren_s;
    logic [3*WIDTH-1:0][AW-1:0]       spec_rd_addr_s;
    logic [3*WIDTH-1:0][PW-1:0]       spec_rd_data_s;
    logic [WIDTH-1:0]                 spec_wr_en_s;
    logic [WIDTH-1:0][AW-1:0]         spec_wr_addr_s;
    logic [WIDTH-1:0][PW-1:0]         spec_wr_data_s;
    logic [WIDTH-1:0]                 ret_wr_en_s;
    logic [NUM_ARCH_REGS-1:0][PW-1:0] ret_map_next_s;
    logic [NUM_ARCH_REGS-1:0][PW-1:0] spec_map_next_s;
    logic [0:0][PW-1:0]               ret_rd_data_s;

    // Which lanes allocate, and each allocating lane's slot in the FRL offer.
    always_comb begin
        dst_s     = '0;
        n_dst_s   = '0;
        frl_idx_s = '0;
        for (int k = 0; k < WIDTH; k++) begin
`ifdef RENAME_ZERO_REG_EN
            dst_s[k] = in_uops[k].lane_valid && in_uops[k].has_dst && (in_uops[k].arch_dst != '0);
`else
            dst_s[k] = in_uops[k].lane_valid && in_uops[k].has_dst;
`endif
            frl_idx_s[k] = IW'(n_dst_s);
            n_dst_s      = n_dst_s + {{(CW-1){1'b0}}, dst_s[k]};
        end
    end

    assign in_ready = !rst && !flush_in && (!out_valid || out_ready) &&
                      ((n_dst_s == '0) || frl_valid_in);
    assign accept_s = in_valid && in_ready;

    // Thermometer acquire mask covering exactly the consumed offer slots.
    always_comb begin
        frl_acquire_out = '0;
        for (int i = 0; i < FREE_W; i++) begin
            frl_acquire_out[i] = accept_s && (i < int'(n_dst_s));
        end
    end

    // Three spec-RAT lookups per lane: src1, src2, and the previous dst mapping.
    always_comb begin
        spec_rd_addr_s = '0;
        for (int k = 0; k < WIDTH; k++) begin
            spec_rd_addr_s[3*k]   = in_uops[k].arch_src1;
            spec_rd_addr_s[3*k+1] = in_uops[k].arch_src2;
            spec_rd_addr_s[3*k+2] = in_uops[k].arch_dst;
        end
    end

    // Rename each lane; a lower lane writing the same arch reg overrides the RAT,
    // and scanning upwards leaves the nearest such lane in place.
    always_comb begin
        ren_s = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (in_uops[k].lane_valid) begin
                ren_s[k].lane_valid   = 1'b1;
                ren_s[k].has_dst      = in_uops[k].has_dst;
                ren_s[k].payload      = in_uops[k].payload;
                ren_s[k].phys_src1    = spec_rd_data_s[3*k];
                ren_s[k].phys_src2    = spec_rd_data_s[3*k+1];
                ren_s[k].old_phys_dst = spec_rd_data_s[3*k+2];
                for (int m = 0; m < WIDTH; m++) begin
                    ren_s[k].phys_src1 = (m < k && dst_s[m] && in_uops[m].arch_dst == in_uops[k].arch_src1) ?
                                         frl_regs_in[frl_idx_s[m]] : ren_s[k].phys_src1;
                    ren_s[k].phys_src2 = (m < k && dst_s[m] && in_uops[m].arch_dst == in_uops[k].arch_src2) ?
                                         frl_regs_in[frl_idx_s[m]] : ren_s[k].phys_src2;
                    ren_s[k].old_phys_dst = (m < k && dst_s[m] && in_uops[m].arch_dst == in_uops[k].arch_dst) ?
                                         frl_regs_in[frl_idx_s[m]] : ren_s[k].old_phys_dst;
                end
`ifdef RENAME_ZERO_REG_EN
                ren_s[k].phys_src1 = (in_uops[k].arch_src1 == '0) ? '0 : ren_s[k].phys_src1;
                ren_s[k].phys_src2 = (in_uops[k].arch_src2 == '0) ? '0 : ren_s[k].phys_src2;
`endif
                ren_s[k].phys_dst     = dst_s[k] ? frl_regs_in[frl_idx_s[k]] : '0;
                ren_s[k].old_phys_dst = dst_s[k] ? ren_s[k].old_phys_dst : '0;
            end else begin
                ren_s[k] = '0;
            end
        end
    end

    // RAT write enables: spec on accept, retire on commit.
    always_comb begin
        spec_wr_en_s   = '0;
        spec_wr_addr_s = '0;
        spec_wr_data_s = '0;
        ret_wr_en_s    = '0;
        for (int k = 0; k < WIDTH; k++) begin
            spec_wr_en_s[k]   = accept_s && dst_s[k];
            spec_wr_addr_s[k] = in_uops[k].arch_dst;
            spec_wr_data_s[k] = ren_s[k].phys_dst;
`ifdef RENAME_ZERO_REG_EN
            ret_wr_en_s[k]    = commit_valid[k] && (commit_arch_dst[k] != '0);
`else
            ret_wr_en_s[k]    = commit_valid[k];
`endif
        end
    end

    rat_bank #(
        .NUM_ARCH_REGS (NUM_ARCH_REGS),
        .NUM_PHYS_REGS (NUM_PHYS_REGS),
        .NRD           (3 * WIDTH),
        .NWR           (WIDTH)
    ) u_spec_rat (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (spec_rd_addr_s),
        .rd_data   (spec_rd_data_s),
        .wr_en     (spec_wr_en_s),
        .wr_addr   (spec_wr_addr_s),
        .wr_data   (spec_wr_data_s),
        .copy_en   (flush_in),
        .copy_data (ret_map_next_s),
        .map_next  (spec_map_next_s)
    );

    rat_bank #(
        .NUM_ARCH_REGS (NUM_ARCH_REGS),
        .NUM_PHYS_REGS (NUM_PHYS_REGS),
        .NRD           (1),
        .NWR           (WIDTH)
    ) u_retire_rat (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   ('0),
        .rd_data   (ret_rd_data_s),
        .wr_en     (ret_wr_en_s),
        .wr_addr   (commit_arch_dst),
        .wr_data   (commit_phys_dst),
        .copy_en   (1'b0),
        .copy_data ('0),
        .map_next  (ret_map_next_s)
    );

    // One-deep output register; flush and reset drop any held group.
    always_ff @(posedge clk) begin
        if (rst || flush_in) begin
            out_valid <= 1'b0;
            out_uops  <= '0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_uops  <= ren_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: directed table, hand sequences and a
// randomized run against a sequential-rename reference model.
module tb_rename_stage;
    import rob_pkg::*;

    localparam int W = INSTR_Q_WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst, in_valid, in_ready, frl_valid_in;
    logic                         out_valid, out_ready, flush_in;
    arch_uop_t    [W-1:0]         in_uops;
    logic [FREE_W-1:0][PW-1:0]    frl_regs_in;
    logic [FREE_W-1:0]            frl_acquire_out;
    renamed_uop_t [W-1:0]         out_uops;
    logic [W-1:0]                 commit_valid;
    logic [W-1:0][AW-1:0]         commit_arch_dst;
    logic [W-1:0][PW-1:0]         commit_phys_dst;

    rename_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_uops(in_uops),
        .frl_valid_in(frl_valid_in), .frl_regs_in(frl_regs_in), .frl_acquire_out(frl_acquire_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_uops(out_uops),
        .commit_valid(commit_valid), .commit_arch_dst(commit_arch_dst),
        .commit_phys_dst(commit_phys_dst), .flush_in(flush_in)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: plain arrays for both maps, a rolling free-register base.
    int           m_spec [NUM_ARCH_REGS];
    int           m_ret  [NUM_ARCH_REGS];
    int           frl_base;
    bit           m_out_valid;
    bit           m_out_known;
    renamed_uop_t [W-1:0] m_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int frl_reg(input int i);
        return 32 + ((frl_base - 32 + i) % 96);
    endfunction

    function automatic bit is_zero_arch(input int a);
`ifdef RENAME_ZERO_REG_EN
        return a == 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit lane_allocs(input int k);
        return in_uops[k].lane_valid && in_uops[k].has_dst && !is_zero_arch(int'(in_uops[k].arch_dst));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            m_spec[i] = i;
            m_ret[i]  = i;
        end
        m_out_valid = 1'b0;
        m_out       = '0;
        m_out_known = 1'b1;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; in_uops = '0; frl_valid_in = 1'b1; out_ready = 1'b1;
        commit_valid = '0; commit_arch_dst = '0; commit_phys_dst = '0; flush_in = 1'b0;
    endtask

    task automatic set_lane(input int k, input bit lv, input bit hd, input int dst, input int s1, input int s2);
        in_uops[k].lane_valid = lv;
        in_uops[k].has_dst    = hd;
        in_uops[k].arch_dst   = AW'(dst);
        in_uops[k].arch_src1  = AW'(s1);
        in_uops[k].arch_src2  = AW'(s2);
        in_uops[k].payload    = PAYLOAD_W'($urandom);
    endtask

    // One clock: check handshake mid-cycle, advance model on the edge, check outputs.
    task automatic cycle();
        int n;
        bit exp_ready, acc;
        int tmp [NUM_ARCH_REGS];
        renamed_uop_t [W-1:0] grp;
        int j;
        for (int i = 0; i < FREE_W; i++) frl_regs_in[i] = PW'(frl_reg(i));
        n = 0;
        for (int k = 0; k < W; k++) n += lane_allocs(k) ? 1 : 0;
        exp_ready = !rst && !flush_in && (!m_out_valid || out_ready) && (n == 0 || frl_valid_in);
        acc = in_valid && exp_ready;
        #1;
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("frl_acquire_out", 64'(frl_acquire_out), acc ? 64'((1 << n) - 1) : 64'd0);
        // Rename lanes one at a time in program order.
        tmp = m_spec;
        j = 0;
        grp = '0;
        for (int k = 0; k < W; k++) begin
            if (in_uops[k].lane_valid) begin
                grp[k].lane_valid   = 1'b1;
                grp[k].has_dst      = in_uops[k].has_dst;
                grp[k].payload      = in_uops[k].payload;
                grp[k].phys_src1    = is_zero_arch(int'(in_uops[k].arch_src1)) ? '0 : PW'(tmp[in_uops[k].arch_src1]);
                grp[k].phys_src2    = is_zero_arch(int'(in_uops[k].arch_src2)) ? '0 : PW'(tmp[in_uops[k].arch_src2]);
                if (lane_allocs(k)) begin
                    grp[k].phys_dst     = PW'(frl_reg(j));
                    grp[k].old_phys_dst = PW'(tmp[in_uops[k].arch_dst]);
                    tmp[in_uops[k].arch_dst] = frl_reg(j);
                    j++;
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (flush_in) begin
                m_out_valid = 1'b0;
                m_out_known = 1'b0;
            end else if (acc) begin
                m_out_valid = 1'b1;
                m_out       = grp;
                m_out_known = 1'b1;
                m_spec      = tmp;
                frl_base    = 32 + ((frl_base - 32 + n) % 96);
            end else if (out_ready) begin
                m_out_valid = 1'b0;
                m_out_known = 1'b0;
            end
            for (int k = 0; k < W; k++) begin
                if (commit_valid[k] && !is_zero_arch(int'(commit_arch_dst[k])))
                    m_ret[commit_arch_dst[k]] = int'(commit_phys_dst[k]);
            end
            if (flush_in) m_spec = m_ret;
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_out_valid));
        if (m_out_known) begin
            for (int k = 0; k < W; k++)
                chk($sformatf("out_uops[%0d]", k), 64'(out_uops[k]), 64'(m_out[k]));
        end
    endtask

    typedef struct {
        logic [W-1:0]        lv, hd;
        logic [W-1:0][4:0]   dst, s1;
        int                  base;
        logic [W-1:0][6:0]   e_pd, e_old, e_s1;
        logic [FREE_W-1:0]   e_acq;
    } vec_t;

    vec_t tbl [4];

    initial begin
        tbl[0] = '{lv: 4'b1111, hd: 4'b1111, dst: {5'd4, 5'd3, 5'd2, 5'd1}, s1: {5'd1, 5'd1, 5'd1, 5'd1}, base: 40,
                   e_pd: {7'd43, 7'd42, 7'd41, 7'd40}, e_old: {7'd4, 7'd3, 7'd2, 7'd1},
                   e_s1: {7'd40, 7'd40, 7'd40, 7'd1}, e_acq: 10'b0000001111};
        tbl[1] = '{lv: 4'b1111, hd: 4'b0101, dst: {5'd9, 5'd5, 5'd9, 5'd5}, s1: {5'd5, 5'd5, 5'd5, 5'd5}, base: 50,
                   e_pd: {7'd0, 7'd51, 7'd0, 7'd50}, e_old: {7'd0, 7'd50, 7'd0, 7'd5},
                   e_s1: {7'd51, 7'd50, 7'd50, 7'd5}, e_acq: 10'b0000000011};
        tbl[2] = '{lv: 4'b0001, hd: 4'b0000, dst: {5'd0, 5'd0, 5'd0, 5'd0}, s1: {5'd4, 5'd4, 5'd4, 5'd5}, base: 52,
                   e_pd: {7'd0, 7'd0, 7'd0, 7'd0}, e_old: {7'd0, 7'd0, 7'd0, 7'd0},
                   e_s1: {7'd0, 7'd0, 7'd0, 7'd51}, e_acq: 10'b0000000000};
        tbl[3] = '{lv: 4'b0011, hd: 4'b0000, dst: {5'd0, 5'd0, 5'd0, 5'd0}, s1: {5'd0, 5'd0, 5'd2, 5'd1}, base: 52,
                   e_pd: {7'd0, 7'd0, 7'd0, 7'd0}, e_old: {7'd0, 7'd0, 7'd0, 7'd0},
                   e_s1: {7'd0, 7'd0, 7'd41, 7'd40}, e_acq: 10'b0000000000};

        clear_inputs();
        frl_base = 32;
        model_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // Directed table.
        for (int v = 0; v < 4; v++) begin
            clear_inputs();
            in_valid = 1'b1;
            frl_base = tbl[v].base;
            for (int k = 0; k < W; k++)
                set_lane(k, tbl[v].lv[k], tbl[v].hd[k], int'(tbl[v].dst[k]), int'(tbl[v].s1[k]), 9);
            #1;
            chk($sformatf("tbl%0d acquire", v), 64'(frl_acquire_out), 64'(tbl[v].e_acq));
            cycle();
            for (int k = 0; k < W; k++) begin
                chk($sformatf("tbl%0d phys_dst[%0d]", v, k), 64'(out_uops[k].phys_dst), 64'(tbl[v].e_pd[k]));
                chk($sformatf("tbl%0d old_phys_dst[%0d]", v, k), 64'(out_uops[k].old_phys_dst), 64'(tbl[v].e_old[k]));
                chk($sformatf("tbl%0d phys_src1[%0d]", v, k), 64'(out_uops[k].phys_src1), 64'(tbl[v].e_s1[k]));
            end
        end

        // FRL not offering while the group needs two registers.
        clear_inputs();
        in_valid = 1'b1; frl_valid_in = 1'b0;
        set_lane(0, 1'b1, 1'b1, 10, 1, 2);
        set_lane(1, 1'b1, 1'b1, 11, 3, 4);
        #1;
        chk("stall in_ready", 64'(in_ready), 64'd0);
        chk("stall acquire", 64'(frl_acquire_out), 64'd0);
        cycle();
        cycle();
        chk("stall out_valid", 64'(out_valid), 64'd0);
        for (int k = 0; k < W; k++) set_lane(k, 1'b1, 1'b0, 0, k + 1, k + 2);
        #1;
        chk("no-dst in_ready", 64'(in_ready), 64'd1);
        cycle();
        chk("no-dst out_valid", 64'(out_valid), 64'd1);

        // Downstream backpressure for three cycles.
        clear_inputs();
        in_valid = 1'b1; frl_base = 80;
        set_lane(0, 1'b1, 1'b1, 12, 1, 2);
        set_lane(1, 1'b1, 1'b1, 13, 12, 2);
        cycle();
        out_ready = 1'b0;
        set_lane(0, 1'b1, 1'b1, 14, 13, 12);
        set_lane(1, 1'b0, 1'b0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold in_ready", 64'(in_ready), 64'd0);
            chk("hold acquire", 64'(frl_acquire_out), 64'd0);
            cycle();
        end
        out_ready = 1'b1;
        #1;
        chk("resume in_ready", 64'(in_ready), 64'd1);
        cycle();
        chk("resume phys_dst", 64'(out_uops[0].phys_dst), 64'd82);

        // Commit then flush restores the committed mapping.
        clear_inputs();
        in_valid = 1'b1; frl_base = 60;
        set_lane(0, 1'b1, 1'b1, 7, 1, 1);
        cycle();
        commit_valid = 4'b0001; commit_arch_dst[0] = AW'(7); commit_phys_dst[0] = PW'(60);
        set_lane(0, 1'b1, 1'b1, 7, 7, 1);
        cycle();
        chk("pre-flush phys_dst", 64'(out_uops[0].phys_dst), 64'd61);
        clear_inputs();
        flush_in = 1'b1;
        cycle();
        chk("flush out_valid", 64'(out_valid), 64'd0);
        clear_inputs();
        in_valid = 1'b1;
        set_lane(0, 1'b1, 1'b0, 0, 7, 7);
        cycle();
        chk("flush restore r7", 64'(out_uops[0].phys_src1), 64'd60);

`ifdef RENAME_ZERO_REG_EN
        clear_inputs();
        in_valid = 1'b1; frl_base = 70;
        set_lane(0, 1'b1, 1'b1, 0, 1, 1);
        set_lane(1, 1'b1, 1'b1, 1, 0, 0);
        #1;
        chk("zero acquire", 64'(frl_acquire_out), 64'd1);
        cycle();
        chk("zero lane0 phys_dst", 64'(out_uops[0].phys_dst), 64'd0);
        chk("zero lane1 phys_dst", 64'(out_uops[1].phys_dst), 64'd70);
`endif

        // Randomized traffic, including flush and mid-run reset.
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            rst          = ($urandom_range(49) == 0);
            in_valid     = ($urandom_range(3) != 0);
            frl_valid_in = ($urandom_range(4) != 0);
            out_ready    = ($urandom_range(9) < 7);
            flush_in     = ($urandom_range(19) == 0);
            for (int k = 0; k < W; k++) begin
                set_lane(k, $urandom_range(3) != 0, $urandom_range(2) != 0,
                         $urandom_range(7), $urandom_range(7), $urandom_range(7));
                commit_valid[k]    = ($urandom_range(3) == 0);
                commit_arch_dst[k] = AW'($urandom_range(7));
                commit_phys_dst[k] = PW'($urandom_range(127));
            end
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
